// File: rtl/dnn_mem_arbiter.sv
// ---------------------------------------------------------------------------
// dnn_mem_arbiter
//
// Merges the DNN accelerator's two AMI request channels onto one downstream
// AMI port. A single holding register drives the downstream request; reads
// record their issuing port in an in-order tag FIFO so that read responses
// can be steered back to the right requester with zero added latency.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   req_*               per-port request (port i at slice i of each bus)
//   req_grant           one-hot acceptance (combinational)
//   dn_req_*            downstream request (registered), dn_req_grant accepts
//   dn_resp_*           downstream read response in, dn_resp_grant consumes
//   resp_valid/data     per-port response valid, shared response data
//   resp_grant          per-port response accept
//   outstanding         tag FIFO occupancy
//   resp_orphan         sticky: response arrived with no outstanding read
//
// Optional build macro DNN_ARB_PERF_EN adds grant_cnt0, grant_cnt1 and
// stall_cnt (32-bit wrapping counters).
// ---------------------------------------------------------------------------
module dnn_mem_arbiter #(
  parameter int ADDR_W    = 64,
  parameter int DATA_W    = 512,
  parameter int SIZE_W    = 7,
  parameter int TAG_DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [1:0]                 req_valid,
  input  logic [1:0]                 req_is_write,
  input  logic [2*ADDR_W-1:0]        req_addr,
  input  logic [2*DATA_W-1:0]        req_data,
  input  logic [2*SIZE_W-1:0]        req_size,
  output logic [1:0]                 req_grant,
  output logic                       dn_req_valid,
  output logic                       dn_req_is_write,
  output logic [ADDR_W-1:0]          dn_req_addr,
  output logic [DATA_W-1:0]          dn_req_data,
  output logic [SIZE_W-1:0]          dn_req_size,
  input  logic                       dn_req_grant,
  input  logic                       dn_resp_valid,
  input  logic [DATA_W-1:0]          dn_resp_data,
  output logic                       dn_resp_grant,
  output logic [1:0]                 resp_valid,
  output logic [DATA_W-1:0]          resp_data,
  input  logic [1:0]                 resp_grant,
  output logic [$clog2(TAG_DEPTH):0] outstanding,
  output logic                       resp_orphan
`ifdef DNN_ARB_PERF_EN
  ,
  output logic [31:0]                grant_cnt0,
  output logic [31:0]                grant_cnt1,
  output logic [31:0]                stall_cnt
`endif
);

  localparam int PTR_W = $clog2(TAG_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_L = CNT_W'(TAG_DEPTH);

  // Port ID of the request currently held in the stage, and arbitration state
  logic                 stage_port_r;
  logic                 last_winner_r;

  // Tag FIFO storage: one bit per entry holding the issuing port ID
  logic [TAG_DEPTH-1:0] tag_mem_r;
  logic [PTR_W-1:0]     wr_ptr_r;
  logic [PTR_W-1:0]     rd_ptr_r;
  logic [CNT_W-1:0]     count_r;

  logic                 stage_free_s;
  logic [CNT_W-1:0]     stage_reads_s;
  logic                 tag_room_s;
  logic [1:0]           elig_s;
  logic                 winner_s;
  logic                 sel_is_write_s;
  logic [ADDR_W-1:0]    sel_addr_s;
  logic [DATA_W-1:0]    sel_data_s;
  logic [SIZE_W-1:0]    sel_size_s;
  logic                 empty_s;
  logic                 head_s;
  logic                 push_s;
  logic                 pop_s;

  // Arbitration: eligibility, round-robin tie-break and winner field select
  always_comb begin
    stage_free_s  = !dn_req_valid || dn_req_grant;
    // A read sitting in the stage will consume a tag when it completes, so it
    // counts against the FIFO budget already.
    stage_reads_s = (dn_req_valid && !dn_req_is_write) ? CNT_W'(1) : CNT_W'(0);
    tag_room_s    = (count_r + stage_reads_s) < DEPTH_L;
    elig_s[0]     = req_valid[0] && (req_is_write[0] || tag_room_s);
    elig_s[1]     = req_valid[1] && (req_is_write[1] || tag_room_s);
    req_grant     = 2'b00;
    winner_s      = 1'b0;
    if (stage_free_s) begin
      case (elig_s)
        2'b01: begin
          req_grant = 2'b01;
          winner_s  = 1'b0;
        end
        2'b10: begin
          req_grant = 2'b10;
          winner_s  = 1'b1;
        end
        2'b11: begin
          if (last_winner_r) begin
            req_grant = 2'b01;
            winner_s  = 1'b0;
          end else begin
            req_grant = 2'b10;
            winner_s  = 1'b1;
          end
        end
        default: begin
          req_grant = 2'b00;
          winner_s  = 1'b0;
        end
      endcase
    end else begin
      req_grant = 2'b00;
      winner_s  = 1'b0;
    end
    if (winner_s) begin
      sel_is_write_s = req_is_write[1];
      sel_addr_s     = req_addr[ADDR_W +: ADDR_W];
      sel_data_s     = req_data[DATA_W +: DATA_W];
      sel_size_s     = req_size[SIZE_W +: SIZE_W];
    end else begin
      sel_is_write_s = req_is_write[0];
      sel_addr_s     = req_addr[0 +: ADDR_W];
      sel_data_s     = req_data[0 +: DATA_W];
      sel_size_s     = req_size[0 +: SIZE_W];
    end
  end

  // Output holding stage: loads on grant, drains when downstream accepts
  always_ff @(posedge clk) begin
    if (reset) begin
      dn_req_valid    <= 1'b0;
      dn_req_is_write <= 1'b0;
      dn_req_addr     <= {ADDR_W{1'b0}};
      dn_req_data     <= {DATA_W{1'b0}};
      dn_req_size     <= {SIZE_W{1'b0}};
      stage_port_r    <= 1'b0;
      last_winner_r   <= 1'b1;
    end else if (req_grant != 2'b00) begin
      dn_req_valid    <= 1'b1;
      dn_req_is_write <= sel_is_write_s;
      dn_req_addr     <= sel_addr_s;
      dn_req_data     <= sel_data_s;
      dn_req_size     <= sel_size_s;
      stage_port_r    <= winner_s;
      last_winner_r   <= winner_s;
    end else if (dn_req_valid && dn_req_grant) begin
      dn_req_valid    <= 1'b0;
    end
  end

  // Response steering from the FIFO head; empty FIFO blocks all routing
  always_comb begin
    empty_s    = (count_r == {CNT_W{1'b0}});
    head_s     = tag_mem_r[rd_ptr_r];
    resp_valid = 2'b00;
    if (dn_resp_valid && !empty_s) begin
      resp_valid[head_s] = 1'b1;
    end else begin
      resp_valid = 2'b00;
    end
    dn_resp_grant = !empty_s && resp_grant[head_s];
    push_s        = dn_req_valid && dn_req_grant && !dn_req_is_write;
    pop_s         = dn_resp_valid && dn_resp_grant;
    resp_data     = dn_resp_data;
    outstanding   = count_r;
  end

  // Tag FIFO payload write; contents are don't-care until pointed at
  always_ff @(posedge clk) begin
    if (push_s) begin
      tag_mem_r[wr_ptr_r] <= stage_port_r;
    end
  end

  // Tag FIFO pointers and occupancy; simultaneous push/pop keeps the count
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Sticky orphan-response flag
  always_ff @(posedge clk) begin
    if (reset) begin
      resp_orphan <= 1'b0;
    end else if (dn_resp_valid && empty_s) begin
      resp_orphan <= 1'b1;
    end
  end

`ifdef DNN_ARB_PERF_EN
  // Performance counters: per-port grants and cycles with demand but no grant
  always_ff @(posedge clk) begin
    if (reset) begin
      grant_cnt0 <= 32'd0;
      grant_cnt1 <= 32'd0;
      stall_cnt  <= 32'd0;
    end else begin
      if (req_grant[0]) begin
        grant_cnt0 <= grant_cnt0 + 32'd1;
      end
      if (req_grant[1]) begin
        grant_cnt1 <= grant_cnt1 + 32'd1;
      end
      if ((req_valid != 2'b00) && (req_grant == 2'b00)) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dnn_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dnn_mem_arbiter
//
// Self-checking bench for dnn_mem_arbiter: a hand-derived vector table, a set
// of multi-cycle corner sequences and a randomized run, all cross-checked
// against a transaction-level reference model (stage record + port-ID queue).
// ---------------------------------------------------------------------------
module tb_dnn_mem_arbiter;

  localparam int ADDR_W    = 64;
  localparam int DATA_W    = 512;
  localparam int SIZE_W    = 7;
  localparam int TAG_DEPTH = 16;

  logic                clk = 1'b0;
  logic                reset;
  logic [1:0]          req_valid;
  logic [1:0]          req_is_write;
  logic [2*ADDR_W-1:0] req_addr;
  logic [2*DATA_W-1:0] req_data;
  logic [2*SIZE_W-1:0] req_size;
  logic [1:0]          req_grant;
  logic                dn_req_valid;
  logic                dn_req_is_write;
  logic [ADDR_W-1:0]   dn_req_addr;
  logic [DATA_W-1:0]   dn_req_data;
  logic [SIZE_W-1:0]   dn_req_size;
  logic                dn_req_grant;
  logic                dn_resp_valid;
  logic [DATA_W-1:0]   dn_resp_data;
  logic                dn_resp_grant;
  logic [1:0]          resp_valid;
  logic [DATA_W-1:0]   resp_data;
  logic [1:0]          resp_grant;
  logic [4:0]          outstanding;
  logic                resp_orphan;
`ifdef DNN_ARB_PERF_EN
  logic [31:0]         grant_cnt0;
  logic [31:0]         grant_cnt1;
  logic [31:0]         stall_cnt;
`endif

  dnn_mem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SIZE_W(SIZE_W), .TAG_DEPTH(TAG_DEPTH)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_is_write(req_is_write), .req_addr(req_addr),
    .req_data(req_data), .req_size(req_size), .req_grant(req_grant),
    .dn_req_valid(dn_req_valid), .dn_req_is_write(dn_req_is_write),
    .dn_req_addr(dn_req_addr), .dn_req_data(dn_req_data),
    .dn_req_size(dn_req_size), .dn_req_grant(dn_req_grant),
    .dn_resp_valid(dn_resp_valid), .dn_resp_data(dn_resp_data),
    .dn_resp_grant(dn_resp_grant), .resp_valid(resp_valid),
    .resp_data(resp_data), .resp_grant(resp_grant),
    .outstanding(outstanding), .resp_orphan(resp_orphan)
`ifdef DNN_ARB_PERF_EN
    , .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1), .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: request stage as a record, outstanding reads as a queue
  bit                m_tags[$];
  logic              m_sv, m_sw, m_sp, m_last, m_orphan;
  logic [ADDR_W-1:0] m_sa;
  logic [DATA_W-1:0] m_sd;
  logic [SIZE_W-1:0] m_ss;

  // DUT combinational outputs sampled mid-cycle
  logic [1:0]        s_gnt, s_rv;
  logic              s_drg;
  logic [DATA_W-1:0] s_rdata;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock cycle with inputs already driven: checks comb outputs at the
  // falling edge, advances the model, checks registered outputs after the edge.
  task automatic cycle();
    logic [1:0] elig, egnt, erv;
    logic       free, empty, head, edrg, win;
    int         inflight;
    @(negedge clk);
    s_gnt = req_grant; s_rv = resp_valid; s_drg = dn_resp_grant; s_rdata = resp_data;
    empty    = (m_tags.size() == 0);
    head     = empty ? 1'b0 : m_tags[0];
    free     = !m_sv || dn_req_grant;
    inflight = m_tags.size() + ((m_sv && !m_sw) ? 1 : 0);
    for (int i = 0; i < 2; i++)
      elig[i] = req_valid[i] && (req_is_write[i] || (inflight < TAG_DEPTH));
    egnt = 2'b00;
    win  = 1'b0;
    if (free && (elig != 2'b00)) begin
      win  = (elig == 2'b11) ? ~m_last : elig[1];
      egnt = win ? 2'b10 : 2'b01;
    end
    erv  = (dn_resp_valid && !empty) ? (head ? 2'b10 : 2'b01) : 2'b00;
    edrg = !empty && resp_grant[head];
    if (!reset) begin
      chk("req_grant", 512'(req_grant), 512'(egnt));
      chk("resp_valid", 512'(resp_valid), 512'(erv));
      chk("dn_resp_grant", 512'(dn_resp_grant), 512'(edrg));
      chk("resp_data", resp_data, dn_resp_data);
    end
    if (reset) begin
      m_tags.delete();
      m_sv = 1'b0; m_sw = 1'b0; m_sp = 1'b0; m_last = 1'b1; m_orphan = 1'b0;
      m_sa = '0; m_sd = '0; m_ss = '0;
    end else begin
      if (dn_resp_valid && edrg) void'(m_tags.pop_front());
      if (m_sv && dn_req_grant && !m_sw) m_tags.push_back(m_sp);
      if (dn_resp_valid && empty) m_orphan = 1'b1;
      if (egnt != 2'b00) begin
        m_sv = 1'b1; m_sp = win; m_last = win;
        m_sw = req_is_write[win];
        m_sa = win ? req_addr[ADDR_W +: ADDR_W] : req_addr[0 +: ADDR_W];
        m_sd = win ? req_data[DATA_W +: DATA_W] : req_data[0 +: DATA_W];
        m_ss = win ? req_size[SIZE_W +: SIZE_W] : req_size[0 +: SIZE_W];
      end else if (dn_req_grant) begin
        m_sv = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    chk("dn_req_valid", 512'(dn_req_valid), 512'(m_sv));
    chk("outstanding", 512'(outstanding), 512'(m_tags.size()));
    chk("resp_orphan", 512'(resp_orphan), 512'(m_orphan));
    if (m_sv) begin
      chk("dn_req_is_write", 512'(dn_req_is_write), 512'(m_sw));
      chk("dn_req_addr", 512'(dn_req_addr), 512'(m_sa));
      chk("dn_req_data", dn_req_data, m_sd);
      chk("dn_req_size", 512'(dn_req_size), 512'(m_ss));
    end
  endtask

  task automatic idle_inputs();
    req_valid = 2'b00; req_is_write = 2'b00; dn_req_grant = 1'b0;
    dn_resp_valid = 1'b0; resp_grant = 2'b00;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
  endtask

  typedef struct {
    logic [1:0] rv, rw;
    logic       dg, drv;
    logic [1:0] rg;
    logic [1:0] e_gnt, e_rv;
    logic       e_drg, e_dv, e_port;
    logic [4:0] e_out;
    logic       e_orph;
  } vec_t;

  vec_t vt[12];
  int   n_gnt, n_resp;
  logic [ADDR_W-1:0] held_addr;

  initial begin
    // rv   rw    dg    drv   rg   | gnt  rv    drg   dv    port  out    orph
    vt[0]  = '{2'b11, 2'b00, 1'b1, 1'b0, 2'b00, 2'b01, 2'b00, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0};
    vt[1]  = '{2'b11, 2'b00, 1'b1, 1'b0, 2'b00, 2'b10, 2'b00, 1'b0, 1'b1, 1'b1, 5'd1, 1'b0};
    vt[2]  = '{2'b11, 2'b00, 1'b1, 1'b1, 2'b01, 2'b01, 2'b01, 1'b1, 1'b1, 1'b0, 5'd1, 1'b0};
    vt[3]  = '{2'b00, 2'b00, 1'b1, 1'b1, 2'b10, 2'b00, 2'b10, 1'b1, 1'b0, 1'b0, 5'd1, 1'b0};
    vt[4]  = '{2'b00, 2'b00, 1'b0, 1'b1, 2'b00, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0, 5'd1, 1'b0};
    vt[5]  = '{2'b10, 2'b10, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 1'b0, 1'b1, 1'b1, 5'd1, 1'b0};
    vt[6]  = '{2'b01, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 1'b1, 5'd1, 1'b0};
    vt[7]  = '{2'b01, 2'b00, 1'b1, 1'b0, 2'b00, 2'b01, 2'b00, 1'b0, 1'b1, 1'b0, 5'd1, 1'b0};
    vt[8]  = '{2'b00, 2'b00, 1'b1, 1'b1, 2'b01, 2'b00, 2'b01, 1'b1, 1'b0, 1'b0, 5'd1, 1'b0};
    vt[9]  = '{2'b00, 2'b00, 1'b0, 1'b1, 2'b11, 2'b00, 2'b01, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0};
    vt[10] = '{2'b00, 2'b00, 1'b0, 1'b1, 2'b11, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1};
    vt[11] = '{2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1};

    idle_inputs();
    reset = 1'b1;
    req_addr = {64'h2222, 64'h1111};
    req_data = {{16{32'hbbbb_0002}}, {16{32'haaaa_0001}}};
    req_size = {7'd64, 7'd32};
    dn_resp_data = '0;
    @(posedge clk);
    #1;
    do_reset();
    chk("rst_dn_is_write", 512'(dn_req_is_write), 512'(1'b0));
    chk("rst_dn_addr", 512'(dn_req_addr), 512'(0));
    chk("rst_dn_data", dn_req_data, 512'(0));
    chk("rst_dn_size", 512'(dn_req_size), 512'(0));
    chk("rst_req_grant", 512'(req_grant), 512'(0));
    chk("rst_dn_resp_grant", 512'(dn_resp_grant), 512'(0));

    // Vector table
    for (int k = 0; k < 12; k++) begin
      req_valid = vt[k].rv; req_is_write = vt[k].rw; dn_req_grant = vt[k].dg;
      dn_resp_valid = vt[k].drv; resp_grant = vt[k].rg;
      dn_resp_data = {16{32'(k)}};
      cycle();
      chk("tbl_grant", 512'(s_gnt), 512'(vt[k].e_gnt));
      chk("tbl_resp_valid", 512'(s_rv), 512'(vt[k].e_rv));
      chk("tbl_dn_resp_grant", 512'(s_drg), 512'(vt[k].e_drg));
      chk("tbl_dn_valid", 512'(dn_req_valid), 512'(vt[k].e_dv));
      if (vt[k].e_dv)
        chk("tbl_dn_addr", 512'(dn_req_addr), vt[k].e_port ? 512'(64'h2222) : 512'(64'h1111));
      chk("tbl_outstanding", 512'(outstanding), 512'(vt[k].e_out));
      chk("tbl_orphan", 512'(resp_orphan), 512'(vt[k].e_orph));
    end

    // Alternating reads with immediate responses carrying data 0..7
    do_reset();
    n_gnt = 0; n_resp = 0;
    req_is_write = 2'b00; dn_req_grant = 1'b1; resp_grant = 2'b11;
    for (int c = 0; c < 30; c++) begin
      req_valid = (n_gnt < 8) ? 2'b11 : 2'b00;
      dn_resp_valid = (m_tags.size() != 0);
      dn_resp_data = 512'(n_resp);
      cycle();
      if (s_gnt != 2'b00) begin
        chk("alt_grant", 512'(s_gnt), (n_gnt % 2 == 1) ? 512'(2'b10) : 512'(2'b01));
        n_gnt++;
      end
      if (s_rv != 2'b00) begin
        chk("alt_resp_port", 512'(s_rv), (n_resp % 2 == 1) ? 512'(2'b10) : 512'(2'b01));
        chk("alt_resp_data", s_rdata, 512'(n_resp));
        n_resp++;
      end
    end
    chk("alt_resp_count", 512'(n_resp), 512'(8));

    // Fill the tag FIFO from port 0, then a write still gets through
    do_reset();
    n_gnt = 0;
    req_valid = 2'b01; req_is_write = 2'b00; dn_req_grant = 1'b1;
    for (int c = 0; c < 40; c++) begin
      cycle();
      if (s_gnt != 2'b00) n_gnt++;
    end
    chk("full_read_grants", 512'(n_gnt), 512'(16));
    chk("full_outstanding", 512'(outstanding), 512'(16));
    req_is_write = 2'b01;
    cycle();
    chk("full_write_grant", 512'(s_gnt), 512'(2'b01));
    req_is_write = 2'b00;
    cycle();
    chk("full_read_blocked", 512'(s_gnt), 512'(2'b00));
    dn_resp_valid = 1'b1; resp_grant = 2'b01;
    cycle();
    chk("full_pop_grant", 512'(s_drg), 512'(1'b1));
    chk("full_pop_count", 512'(outstanding), 512'(15));
    dn_resp_valid = 1'b0;
    cycle();
    chk("full_read_resumes", 512'(s_gnt), 512'(2'b01));

    // Downstream stall holds the stage for 5 cycles
    do_reset();
    req_addr = {64'h2222, 64'h0000_beef_0000_1234};
    req_valid = 2'b01; req_is_write = 2'b00; dn_req_grant = 1'b0;
    cycle();
    held_addr = 64'h0000_beef_0000_1234;
    req_valid = 2'b11;
    for (int c = 0; c < 5; c++) begin
      req_addr = {32'h0, $urandom(), 32'h0, $urandom()};
      cycle();
      chk("stall_grant", 512'(s_gnt), 512'(2'b00));
      chk("stall_addr", 512'(dn_req_addr), 512'(held_addr));
      chk("stall_valid", 512'(dn_req_valid), 512'(1'b1));
    end
    req_valid = 2'b00; dn_req_grant = 1'b1;
    cycle();
    chk("stall_release_out", 512'(outstanding), 512'(1));

    // Response back-pressure: three refused cycles, then one pop
    dn_req_grant = 1'b0; dn_resp_valid = 1'b1; resp_grant = 2'b10;
    for (int c = 0; c < 3; c++) begin
      cycle();
      chk("bp_no_grant", 512'(s_drg), 512'(1'b0));
      chk("bp_hold_count", 512'(outstanding), 512'(1));
    end
    resp_grant = 2'b01;
    cycle();
    chk("bp_pop", 512'(s_drg), 512'(1'b1));
    chk("bp_count", 512'(outstanding), 512'(0));
    dn_resp_valid = 1'b0;

    // Reset with reads outstanding and a request in the stage
    do_reset();
    req_valid = 2'b01; req_is_write = 2'b00; dn_req_grant = 1'b1;
    for (int c = 0; c < 5; c++) cycle();
    chk("mid_outstanding", 512'(outstanding), 512'(4));
    chk("mid_stage", 512'(dn_req_valid), 512'(1'b1));
    req_valid = 2'b11; dn_req_grant = 1'b0; reset = 1'b1;
    cycle();
    reset = 1'b0;
    chk("mid_rst_out", 512'(outstanding), 512'(0));
    chk("mid_rst_valid", 512'(dn_req_valid), 512'(1'b0));
    cycle();
    chk("mid_rst_tie", 512'(s_gnt), 512'(2'b01));

    // Randomized traffic against the model
    do_reset();
    for (int c = 0; c < 600; c++) begin
      reset         = ($urandom_range(0, 199) == 0);
      req_valid     = 2'($urandom());
      req_is_write  = ($urandom_range(0, 3) == 0) ? 2'($urandom()) : 2'b00;
      req_addr      = {$urandom(), $urandom(), $urandom(), $urandom()};
      req_data      = {32{$urandom()}};
      req_size      = 14'($urandom());
      dn_req_grant  = ($urandom_range(0, 9) < 7);
      dn_resp_valid = ($urandom_range(0, 9) < 3);
      dn_resp_data  = {16{$urandom()}};
      resp_grant    = 2'($urandom());
      cycle();
    end
    reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dnn_mem_arbiter.md
# dnn_mem_arbiter

Two-requester memory arbiter that merges the DNN accelerator's two AMI memory request channels into a single downstream AMI port. Responses are routed back to the issuing requester in order. It sits between the accelerator top and the shell's single memory channel, beside the soft-register start/cycle-count FSM. Read ordering is preserved by an in-order tag FIFO that records which port issued each read.

## Interface

Parameters:
- ADDR_W, 64, request address width
- DATA_W, 512, request/response data width
- SIZE_W, 7, transfer size field width in bytes (max 64)
- TAG_DEPTH, 16, maximum outstanding reads; must be a power of 2, minimum 2

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- req_valid  in  2  per-port request valid
- req_is_write  in  2  per-port write flag
- req_addr  in  2*ADDR_W  per-port address; port i occupies bits [i*ADDR_W +: ADDR_W]
- req_data  in  2*DATA_W  per-port write data
- req_size  in  2*SIZE_W  per-port size
- req_grant  out  2  one-hot acceptance, combinational
- dn_req_valid  out  1  downstream request valid, registered
- dn_req_is_write, dn_req_addr, dn_req_data, dn_req_size  out  1/ADDR_W/DATA_W/SIZE_W  downstream request fields, registered
- dn_req_grant  in  1  downstream accepts
- dn_resp_valid  in  1  downstream read data valid
- dn_resp_data  in  DATA_W  downstream read data
- dn_resp_grant  out  1  response consumed
- resp_valid  out  2  per-port response valid
- resp_data  out  DATA_W  shared response data, equal to dn_resp_data
- resp_grant  in  2  per-port response accept
- outstanding  out  log2(TAG_DEPTH)+1  current tag FIFO occupancy
- resp_orphan  out  1  sticky error: a response arrived with no outstanding read

## Operation

- Output stage: a single holding register drives the dn_req_* signals.
- The stage is free when !dn_req_valid, or when dn_req_valid && dn_req_grant in the current cycle.
- Eligibility: port i is eligible when req_valid[i] and either req_is_write[i] is set, or (outstanding + reads already in the stage) < TAG_DEPTH.
- Selection happens only when the stage is free.
  - If exactly one port is eligible, it wins.
  - If both are eligible, the port other than last_winner wins.
- When port i wins:
  - req_grant[i]=1.
  - Its fields load into the stage.
  - last_winner is set to i.
- Tag FIFO push: when a read request completes downstream (dn_req_valid && dn_req_grant && !dn_req_is_write), the winning port ID is pushed.
- Writes produce no response and push nothing.
- Response routing, with head = FIFO head port ID:
  - resp_valid[head] = dn_resp_valid && !empty.
  - The other resp_valid bit is 0.
  - dn_resp_grant = resp_grant[head] && !empty.
  - The FIFO pops when dn_resp_valid && dn_resp_grant.
- Push and pop in the same cycle leave occupancy unchanged; both operations take effect.
- Empty FIFO with dn_resp_valid:
  - dn_resp_grant=0 and resp_valid=0.
  - resp_orphan is set and stays set until reset.
- Full FIFO: reads are not eligible; writes still arbitrate normally.
- Reset mid-operation clears the stage, the FIFO, last_winner and resp_orphan. In-flight responses are dropped.

## Timing

- Reset values:
  - dn_req_valid=0, all other dn_req_* fields 0.
  - req_grant=0 and dn_resp_grant=0.
  - resp_valid=0, outstanding=0, resp_orphan=0.
  - last_winner=1, so port 0 wins the first tie.
- A request granted in cycle N appears on dn_req_* in cycle N+1.
- Back-to-back: with dn_req_grant held at 1, one request is issued every cycle (full throughput).
- dn_req_* fields stay stable while dn_req_valid && !dn_req_grant.
- Response path is combinational: zero added latency, no buffering.
- outstanding updates the cycle after a push or pop.

## Configuration

- DNN_ARB_PERF_EN defined:
  - Adds outputs grant_cnt0, grant_cnt1 (32 bits each).
  - Adds a 32-bit stall_cnt that increments each cycle some req_valid is set but no req_grant is issued.
  - All counters wrap at 2^32 and clear on reset.
- Undefined: these ports and counters do not exist. All other behaviour is identical.

## Test plan

- Both ports hold continuous reads, dn_req_grant=1, responses returned immediately -> grants alternate 0,1,0,1. Each of 8 responses carries data 0..7 and lands on resp_valid of the correct port in order.
- Port 0 issues 16 reads with no responses (TAG_DEPTH=16), then issues a write -> read grants stop at outstanding=16 and the write is still granted. The first response pop re-enables reads.
- dn_req_grant held 0 for 5 cycles with a request in the stage -> dn_req_* fields stay stable, req_grant=0, and no request is lost. Release -> the request issues next cycle.
- dn_resp_valid=1 with the FIFO empty -> dn_resp_grant=0, resp_valid=0, resp_orphan=1 and it stays set.
- resp_grant[head]=0 for 3 cycles while dn_resp_valid=1 -> no pop, dn_resp_grant=0. Then resp_grant=1 -> single pop, outstanding decrements by 1.
- Reset asserted with 4 reads outstanding and a request pending in the stage -> next cycle outstanding=0, dn_req_valid=0. The next tie is won by port 0.
